// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared types and constants for the RVFI extension generator.
package ibex_pkg;

    typedef struct packed {
        logic [31:0] mip;
        logic        nmi;
        logic        nmi_int;
        logic        debug_req;
        logic        debug_mode;
        logic        irq_valid;
    } rvfi_ext_issue_t;

    localparam int unsigned RVFI_EXT_DEPTH_DEFAULT = 2;

endpackage

// File: rtl/ibex_rvfi_ext_fifo.sv
// rtl/ibex_rvfi_ext_fifo.sv - in-order snapshot FIFO with flush; a pop in the flush cycle completes before the clear.
module ibex_rvfi_ext_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned DEPTH = RVFI_EXT_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  rvfi_ext_issue_t wdata,
    input  logic            pop,
    input  logic            flush,
    output rvfi_ext_issue_t rdata,
    output logic            full,
    output logic            empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    rvfi_ext_issue_t mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [PW-1:0]   rptr_next;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign rdata     = mem[rptr];
    assign do_pop    = pop & ~empty;
    // A flush frees every slot, so a push in the flush cycle always lands.
    assign do_push   = push & (~full | do_pop | flush);
    assign rptr_next = rptr + PW'(do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= rptr_next;
            wptr  <= rptr_next + PW'(do_push);
            count <= CW'(do_push);
        end else begin
            rptr  <= rptr_next;
            wptr  <= wptr + PW'(do_push);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[flush ? rptr_next : wptr] <= wdata;
        end
    end

endmodule

// File: rtl/ibex_rvfi_ext_gen.sv
// rtl/ibex_rvfi_ext_gen.sv - RVFI extension producer: issue-time snapshots aligned to retirement.
// RVFI_EXT_PERF_EN enables the retire-time mcycle/hpm counter registers.
module ibex_rvfi_ext_gen
    import ibex_pkg::*;
#(
    parameter int unsigned DEPTH          = RVFI_EXT_DEPTH_DEFAULT,
    parameter int unsigned MHPMCounterNum = 10
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           issue_i,
    input  logic                           retire_i,
    input  logic                           flush_i,
    input  logic [31:0]                    mip_i,
    input  logic                           nmi_i,
    input  logic                           nmi_int_i,
    input  logic                           debug_req_i,
    input  logic                           debug_mode_i,
    input  logic                           irq_valid_i,
    input  logic                           rf_wr_suppress_i,
    input  logic                           ic_scr_key_valid_i,
    input  logic [63:0]                    mcycle_i,
    input  logic [MHPMCounterNum-1:0][31:0] mhpmcounters_i,
    input  logic [MHPMCounterNum-1:0][31:0] mhpmcountersh_i,
    output logic                           rvfi_valid_o,
    output logic [31:0]                    rvfi_ext_mip_o,
    output logic                           rvfi_ext_nmi_o,
    output logic                           rvfi_ext_nmi_int_o,
    output logic                           rvfi_ext_debug_req_o,
    output logic                           rvfi_ext_debug_mode_o,
    output logic                           rvfi_ext_irq_valid_o,
    output logic                           rvfi_ext_rf_wr_suppress_o,
    output logic                           rvfi_ext_ic_scr_key_valid_o,
    output logic [63:0]                    rvfi_ext_mcycle_o,
    output logic [MHPMCounterNum-1:0][31:0] rvfi_ext_mhpmcounters_o,
    output logic [MHPMCounterNum-1:0][31:0] rvfi_ext_mhpmcountersh_o,
    output logic                           err_overflow_o,
    output logic                           err_underflow_o
);

    rvfi_ext_issue_t live;
    rvfi_ext_issue_t fifo_rdata;
    rvfi_ext_issue_t ret_issue;
    rvfi_ext_issue_t issue_q;
    logic            fifo_full;
    logic            fifo_empty;
    logic            bypass;
    logic            rf_wr_suppress_q;
    logic            ic_scr_key_valid_q;

    assign live = '{mip: mip_i, nmi: nmi_i, nmi_int: nmi_int_i, debug_req: debug_req_i,
                    debug_mode: debug_mode_i, irq_valid: irq_valid_i};

    // Issue and retire of the same instruction into an empty buffer never touch storage.
    assign bypass = issue_i & retire_i & fifo_empty;

    ibex_rvfi_ext_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk_i),
        .rst_n(rst_ni),
        .push (issue_i & ~bypass),
        .wdata(live),
        .pop  (retire_i),
        .flush(flush_i),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        ret_issue = fifo_rdata;
        if (fifo_empty) begin
            ret_issue = issue_i ? live : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvfi_valid_o       <= 1'b0;
            issue_q            <= '0;
            rf_wr_suppress_q   <= 1'b0;
            ic_scr_key_valid_q <= 1'b0;
            err_overflow_o     <= 1'b0;
            err_underflow_o    <= 1'b0;
        end else begin
            rvfi_valid_o <= retire_i;
            if (retire_i) begin
                issue_q            <= ret_issue;
                rf_wr_suppress_q   <= rf_wr_suppress_i;
                ic_scr_key_valid_q <= ic_scr_key_valid_i;
            end
            if (issue_i && fifo_full && !retire_i && !flush_i) begin
                err_overflow_o <= 1'b1;
            end
            if (retire_i && fifo_empty && !issue_i) begin
                err_underflow_o <= 1'b1;
            end
        end
    end

    assign rvfi_ext_mip_o              = issue_q.mip;
    assign rvfi_ext_nmi_o              = issue_q.nmi;
    assign rvfi_ext_nmi_int_o          = issue_q.nmi_int;
    assign rvfi_ext_debug_req_o        = issue_q.debug_req;
    assign rvfi_ext_debug_mode_o       = issue_q.debug_mode;
    assign rvfi_ext_irq_valid_o        = issue_q.irq_valid;
    assign rvfi_ext_rf_wr_suppress_o   = rf_wr_suppress_q;
    assign rvfi_ext_ic_scr_key_valid_o = ic_scr_key_valid_q;

`ifdef RVFI_EXT_PERF_EN
    logic [63:0]                     mcycle_q;
    logic [MHPMCounterNum-1:0][31:0] mhpm_q;
    logic [MHPMCounterNum-1:0][31:0] mhpmh_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcycle_q <= '0;
            mhpm_q   <= '0;
            mhpmh_q  <= '0;
        end else if (retire_i) begin
            mcycle_q <= mcycle_i;
            mhpm_q   <= mhpmcounters_i;
            mhpmh_q  <= mhpmcountersh_i;
        end
    end

    assign rvfi_ext_mcycle_o        = mcycle_q;
    assign rvfi_ext_mhpmcounters_o  = mhpm_q;
    assign rvfi_ext_mhpmcountersh_o = mhpmh_q;
`else
    logic unused_perf;
    assign unused_perf              = ^{mcycle_i, mhpmcounters_i, mhpmcountersh_i};
    assign rvfi_ext_mcycle_o        = '0;
    assign rvfi_ext_mhpmcounters_o  = '0;
    assign rvfi_ext_mhpmcountersh_o = '0;
`endif

endmodule

// File: tb/tb_ibex_rvfi_ext_gen.sv
// tb/tb_ibex_rvfi_ext_gen.sv - scoreboard bench for ibex_rvfi_ext_gen.
module tb_ibex_rvfi_ext_gen;
    import ibex_pkg::*;

    localparam int DEPTH = 2;
    localparam int NC    = 10;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 issue_i = 0, retire_i = 0, flush_i = 0;
    logic [31:0]          mip_i = '0;
    logic                 nmi_i = 0, nmi_int_i = 0, debug_req_i = 0, debug_mode_i = 0, irq_valid_i = 0;
    logic                 rf_wr_suppress_i = 0, ic_scr_key_valid_i = 0;
    logic [63:0]          mcycle_i = '0;
    logic [NC-1:0][31:0]  hpm_i = '0, hpmh_i = '0;

    logic                 rvfi_valid_o;
    logic [31:0]          mip_o;
    logic                 nmi_o, nmi_int_o, debug_req_o, debug_mode_o, irq_valid_o;
    logic                 rf_o, ic_o;
    logic [63:0]          mcycle_o;
    logic [NC-1:0][31:0]  hpm_o, hpmh_o;
    logic                 ovf_o, udf_o;

    always #5 clk = ~clk;

    ibex_rvfi_ext_gen #(.DEPTH(DEPTH), .MHPMCounterNum(NC)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .issue_i(issue_i), .retire_i(retire_i), .flush_i(flush_i),
        .mip_i(mip_i), .nmi_i(nmi_i), .nmi_int_i(nmi_int_i), .debug_req_i(debug_req_i),
        .debug_mode_i(debug_mode_i), .irq_valid_i(irq_valid_i),
        .rf_wr_suppress_i(rf_wr_suppress_i), .ic_scr_key_valid_i(ic_scr_key_valid_i),
        .mcycle_i(mcycle_i), .mhpmcounters_i(hpm_i), .mhpmcountersh_i(hpmh_i),
        .rvfi_valid_o(rvfi_valid_o), .rvfi_ext_mip_o(mip_o), .rvfi_ext_nmi_o(nmi_o),
        .rvfi_ext_nmi_int_o(nmi_int_o), .rvfi_ext_debug_req_o(debug_req_o),
        .rvfi_ext_debug_mode_o(debug_mode_o), .rvfi_ext_irq_valid_o(irq_valid_o),
        .rvfi_ext_rf_wr_suppress_o(rf_o), .rvfi_ext_ic_scr_key_valid_o(ic_o),
        .rvfi_ext_mcycle_o(mcycle_o), .rvfi_ext_mhpmcounters_o(hpm_o),
        .rvfi_ext_mhpmcountersh_o(hpmh_o), .err_overflow_o(ovf_o), .err_underflow_o(udf_o)
    );

    typedef struct {
        rvfi_ext_issue_t iss;
        logic            rf;
        logic            ic;
        logic [63:0]     mcy;
        logic [31:0]     c0, cl, h0, hl;
    } exp_t;

    exp_t            eq[$];
    rvfi_ext_issue_t mq[$];
    exp_t            mon_e;
    logic            m_ovf = 0, m_udf = 0;
    int              errors = 0, checks = 0;
    int              valid_seen = 0, retires = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] perf(input logic [63:0] v);
`ifdef RVFI_EXT_PERF_EN
        return v;
`else
        return 64'(v & 64'h0);
`endif
    endfunction

    function automatic rvfi_ext_issue_t mk(input logic [31:0] mip, input logic nmi, input logic dreq);
        rvfi_ext_issue_t d;
        d = '0;
        d.mip = mip;
        d.nmi = nmi;
        d.debug_req = dreq;
        return d;
    endfunction

    task automatic step(input logic iss, input logic ret, input logic fl,
                        input rvfi_ext_issue_t d, input logic [63:0] mcy);
        exp_t e;
        logic empty, full, byp;
        issue_i = iss; retire_i = ret; flush_i = fl;
        mip_i = d.mip; nmi_i = d.nmi; nmi_int_i = d.nmi_int; debug_req_i = d.debug_req;
        debug_mode_i = d.debug_mode; irq_valid_i = d.irq_valid;
        mcycle_i = mcy;
        rf_wr_suppress_i = 1'($urandom); ic_scr_key_valid_i = 1'($urandom);
        for (int i = 0; i < NC; i++) begin
            hpm_i[i] = $urandom; hpmh_i[i] = $urandom;
        end
        empty = (mq.size() == 0);
        full  = (mq.size() == DEPTH);
        byp   = iss && ret && empty;
        if (ret) begin
            if (byp)        e.iss = d;
            else if (empty) e.iss = '0;
            else            e.iss = mq.pop_front();
            e.rf = rf_wr_suppress_i; e.ic = ic_scr_key_valid_i;
            e.mcy = perf(mcy);
            e.c0 = 32'(perf(64'(hpm_i[0])));   e.cl = 32'(perf(64'(hpm_i[NC-1])));
            e.h0 = 32'(perf(64'(hpmh_i[0])));  e.hl = 32'(perf(64'(hpmh_i[NC-1])));
            eq.push_back(e);
            retires++;
        end
        if (fl) mq.delete();
        if (iss && !byp) begin
            if (fl || ret || !full) mq.push_back(d);
            else m_ovf = 1'b1;
        end
        if (ret && empty && !iss) m_udf = 1'b1;
        @(posedge clk);
        #1;
        issue_i = 0; retire_i = 0; flush_i = 0;
        check("err_overflow", 64'(ovf_o), 64'(m_ovf));
        check("err_underflow", 64'(udf_o), 64'(m_udf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && rvfi_valid_o) begin
            valid_seen++;
            if (eq.size() == 0) begin
                check("spurious_valid", 64'(rvfi_valid_o), 64'd0);
            end else begin
                mon_e = eq.pop_front();
                check("mip", 64'(mip_o), 64'(mon_e.iss.mip));
                check("issue_flags", 64'({nmi_o, nmi_int_o, debug_req_o, debug_mode_o, irq_valid_o}),
                      64'({mon_e.iss.nmi, mon_e.iss.nmi_int, mon_e.iss.debug_req,
                           mon_e.iss.debug_mode, mon_e.iss.irq_valid}));
                check("retire_flags", 64'({rf_o, ic_o}), 64'({mon_e.rf, mon_e.ic}));
                check("mcycle", mcycle_o, mon_e.mcy);
                check("hpm", {hpm_o[0], hpm_o[NC-1]}, {mon_e.c0, mon_e.cl});
                check("hpmh", {hpmh_o[0], hpmh_o[NC-1]}, {mon_e.h0, mon_e.hl});
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 64'(rvfi_valid_o), 64'd0);
        check({tag, "_mip"}, 64'(mip_o), 64'd0);
        check({tag, "_flags"}, 64'({nmi_o, nmi_int_o, debug_req_o, debug_mode_o, irq_valid_o, rf_o, ic_o}), 64'd0);
        check({tag, "_mcycle"}, mcycle_o, 64'd0);
        check({tag, "_hpm"}, 64'(|{hpm_o, hpmh_o}), 64'd0);
        check({tag, "_err"}, 64'({ovf_o, udf_o}), 64'd0);
        check({tag, "_count"}, 64'(u_dut.u_fifo.count), 64'd0);
    endtask

    initial begin
        rvfi_ext_issue_t d;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Single snapshot held across idle cycles, then retired.
        step(1, 0, 0, mk(32'h0000_0880, 0, 0), 64'd0);
        idle(3);
        step(0, 1, 0, '0, 64'd100);
        idle(1);
        check("hold_valid", 64'(rvfi_valid_o), 64'd0);
        check("hold_mip", 64'(mip_o), 64'h880);

        // In-order retirement.
        step(1, 0, 0, mk(32'h11, 1, 0), 64'd0);
        step(1, 0, 0, mk(32'h22, 0, 0), 64'd0);
        step(0, 1, 0, '0, 64'd200);
        step(0, 1, 0, '0, 64'd201);
        idle(1);

        // Overflow: third push dropped.
        step(1, 0, 0, mk(32'h1, 0, 0), 64'd0);
        step(1, 0, 0, mk(32'h2, 0, 0), 64'd0);
        step(1, 0, 0, mk(32'h3, 0, 0), 64'd0);
        step(0, 1, 0, '0, 64'd300);
        step(0, 1, 0, '0, 64'd301);
        idle(1);

        // Bypass on empty buffer.
        step(1, 1, 0, mk(32'h55, 0, 1), 64'd400);
        check("bypass_count", 64'(u_dut.u_fifo.count), 64'd0);
        idle(1);

        // Flush + retire + issue in one cycle.
        step(1, 0, 0, mk(32'h4, 0, 0), 64'd0);
        step(1, 1, 1, mk(32'h8, 0, 0), 64'd500);
        check("flush_count", 64'(u_dut.u_fifo.count), 64'd1);
        step(0, 1, 0, '0, 64'd501);
        idle(1);

        // Underflow: retire on empty buffer.
        step(0, 1, 0, '0, 64'd600);
        idle(1);

        for (int i = 0; i < 80; i++) begin
            d = '0;
            d.mip = $urandom;
            {d.nmi, d.nmi_int, d.debug_req, d.debug_mode, d.irq_valid} = 5'($urandom);
            step(1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0), d, {$urandom, $urandom});
        end
        idle(2);

        // Asynchronous reset mid-cycle with a snapshot in flight.
        step(1, 0, 0, mk(32'hABC, 1, 1), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        retires -= eq.size();
        eq.delete();
        mq.delete();
        m_ovf = 0;
        m_udf = 0;
        check_outputs_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1, 0, 0, mk(32'h77, 0, 0), 64'd0);
        step(0, 1, 0, '0, 64'd700);
        idle(2);

        check("scoreboard_drained", 64'(eq.size()), 64'd0);
        check("valid_count", 64'(valid_seen), 64'(retires));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ibex_rvfi_ext_gen.md
Name: ibex_rvfi_ext_gen

Overview:
- Producer side of the RVFI extension ("rvfi_ext_*") bundle that the tracer and formal checkers consume.
- Snapshots interrupt and debug state when an instruction issues into execute, and holds it in an in-order buffer until that instruction retires.
- On retirement, presents the snapshot together with retire-time counters, aligned with rvfi_valid.
- Lives inside ibex_core, next to the RVFI pipeline registers. It is compiled only under RVFI.

Parameters:
- DEPTH, 2, number of in-flight instruction snapshots; power of two, minimum 2.
- MHPMCounterNum, 10, number of hpm counter slots presented.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- issue_i  in  1  instruction leaves ID/EX this cycle (push)
- retire_i  in  1  instruction retires this cycle (pop)
- flush_i  in  1  pipeline flush; discards all un-retired snapshots
- mip_i  in  32  live mip
- nmi_i  in  1  NMI pending
- nmi_int_i  in  1  internal NMI pending
- debug_req_i  in  1  debug request
- debug_mode_i  in  1  core in debug mode
- irq_valid_i  in  1  interrupt taken at issue
- rf_wr_suppress_i  in  1  RF write suppressed, sampled at retire
- ic_scr_key_valid_i  in  1  icache scramble key valid, sampled at retire
- mcycle_i  in  64  mcycle, sampled at retire
- mhpmcounters_i  in  32xMHPMCounterNum  low halves, sampled at retire
- mhpmcountersh_i  in  32xMHPMCounterNum  high halves, sampled at retire
- rvfi_valid_o  out  1  ext bundle valid
- rvfi_ext_mip_o  out  32
- rvfi_ext_nmi_o, rvfi_ext_nmi_int_o, rvfi_ext_debug_req_o, rvfi_ext_debug_mode_o, rvfi_ext_irq_valid_o  out  1 each
- rvfi_ext_rf_wr_suppress_o, rvfi_ext_ic_scr_key_valid_o  out  1 each
- rvfi_ext_mcycle_o  out  64
- rvfi_ext_mhpmcounters_o, rvfi_ext_mhpmcountersh_o  out  32xMHPMCounterNum
- err_overflow_o  out  1  sticky: push while full
- err_underflow_o  out  1  sticky: pop while empty

Behaviour:
- Reset: all outputs 0; buffer empty; wptr, rptr and count are 0.
- Buffer: circular FIFO of DEPTH entries holding {mip, nmi, nmi_int, debug_req, debug_mode, irq_valid}. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits.
- Push: issue_i and not full → write the entry at wptr; wptr+1.
- Pop: retire_i and not empty → read the entry at rptr; rptr+1.
- Latency: outputs are registered. rvfi_valid_o=1 in the cycle after retire_i, for exactly one cycle. All rvfi_ext_* outputs hold their last value when rvfi_valid_o=0.
- Retire-time fields (rf_wr_suppress, ic_scr_key_valid, mcycle, counters) are sampled in the retire_i cycle.
- Simultaneous push and pop, not empty and not full: both happen; count unchanged.
- Simultaneous push and pop, full: both happen; no overflow.
- Simultaneous push and pop, empty: bypass. The live issue-time inputs go straight to the outputs; count stays 0.
- Push when full, no pop: push dropped; err_overflow_o set.
- Pop when empty, no push: outputs issue fields as 0, still asserts rvfi_valid_o; err_underflow_o set.
- Error flags stay set until reset.
- flush_i: any same-cycle retire is completed first (oldest entry, or bypass if empty). Then the buffer is cleared: count=0, wptr=rptr. A same-cycle issue_i is pushed after the clear and survives the flush.
- Reset asserted mid-operation: immediate asynchronous clear of buffer and outputs.

Optional Feature:
- Macro: RVFI_EXT_PERF_EN.
- Defined: mcycle, mhpmcounters and mhpmcountersh are registered at retire as described.
- Undefined: those three outputs are tied to 0, their inputs are left unused, and no registers are built for them.
- Ports are identical in both builds.

Decomposition:
- ibex_pkg: rvfi_ext_issue_t struct {mip[31:0], nmi, nmi_int, debug_req, debug_mode, irq_valid}.
- ibex_pkg: constant RVFI_EXT_DEPTH_DEFAULT = 2.
- One sub-module, ibex_rvfi_ext_fifo: a generic DEPTH-deep FIFO of rvfi_ext_issue_t with push/pop/flush and full/empty. The top level owns bypass, output registers and error flags.

Test Plan:
- Push with mip=0x0000_0880 (cycle 1); retire with mcycle=100 (cycle 5) → cycle 6: rvfi_valid_o=1, mip_o=0x880, mcycle_o=100; cycle 7: valid=0, mip_o still 0x880.
- Two pushes with nmi=1 then nmi=0; two retires → outputs nmi=1 then nmi=0 in consecutive cycles (in order).
- Three pushes at DEPTH=2 with no retire → third dropped, err_overflow_o=1. Then two retires return the first two snapshots.
- Empty buffer, issue_i and retire_i same cycle with debug_req_i=1 → next cycle rvfi_valid_o=1, debug_req_o=1, count stays 0.
- One entry held; flush_i, retire_i and issue_i all in the same cycle (mip=0x8) → retired entry output; new entry kept. A later retire outputs mip=0x8.
- Build without RVFI_EXT_PERF_EN, retire with mcycle=0x1234 → mcycle_o=0, mhpmcounters_o all 0.
